// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: GPU pixels and a back-buffer clear engine share one
// registered write stage, with double-buffer swap on drained frame end. Optional stats: FB_STATS_EN.
module fb_write_scheduler #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int ADDR_W  = 20,
  parameter int COLOR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               gpu_valid,
  output logic               gpu_ready,
  input  logic               gpu_draw,
  input  logic [10:0]        gpu_x,
  input  logic [10:0]        gpu_y,
  input  logic [COLOR_W-1:0] gpu_color,
  input  logic               gpu_frame_end,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic               buf_sel,
  output logic               swap_done
`ifdef FB_STATS_EN
  ,
  output logic [31:0]        stat_written,
  output logic [31:0]        stat_dropped,
  output logic [15:0]        stat_frames
`endif
);

  typedef enum logic [1:0] {RUN, CLEAR, DRAIN, SWAP} state_e;

  localparam int FRAME = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOR_W-1:0]  data_q, data_d;
  logic                buf_q, buf_d;
  logic                swap_q, swap_d;
  logic                frame_pend_q, frame_pend_d;
  logic                clr_pend_q, clr_pend_d;
  logic [COLOR_W-1:0]  clr_col_q, clr_col_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic                stage_free, in_range, gpu_hs;
  logic [ADDR_W-1:0]   base, pix_addr;

  // The stage can take a new write in the same cycle its current one is accepted.
  assign stage_free = !we_q || mem_ready;
  assign base       = buf_q ? '0 : FRAME_A;
  assign in_range   = (int'(gpu_x) < H_RES) && (int'(gpu_y) < V_RES);
  assign pix_addr   = base + ADDR_W'(gpu_x) + ADDR_W'(gpu_y) * ADDR_W'(H_RES);
  // A pending clear also holds off the GPU so no pixel can slip in ahead of the fill.
  assign gpu_ready  = !reset && (state_q == RUN) && stage_free && !frame_pend_q && !clr_pend_q;
  assign gpu_hs     = gpu_valid && gpu_ready;

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign clr_busy  = clr_pend_q;
  assign buf_sel   = buf_q;
  assign swap_done = swap_q;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q && !mem_ready;
    addr_d       = addr_q;
    data_d       = data_q;
    buf_d        = buf_q;
    swap_d       = 1'b0;
    cnt_d        = cnt_q;
    frame_pend_d = frame_pend_q || gpu_frame_end;
    clr_pend_d   = clr_pend_q;
    clr_col_d    = clr_col_q;
    if (clr_start && state_q != CLEAR) begin
      clr_pend_d = 1'b1;
      clr_col_d  = clr_color;
    end
    case (state_q)
      RUN: begin
        if (gpu_hs && gpu_draw && in_range) begin
          we_d   = 1'b1;
          addr_d = pix_addr;
          data_d = gpu_color;
        end
        if (frame_pend_q)    state_d = DRAIN;
        else if (clr_pend_q) state_d = CLEAR;
      end
      DRAIN: if (!we_q) state_d = SWAP;
      SWAP: begin
        buf_d        = !buf_q;
        swap_d       = 1'b1;
        frame_pend_d = gpu_frame_end;
        state_d      = clr_pend_q ? CLEAR : RUN;
      end
      CLEAR: begin
        // cnt_q == FRAME means every fill word is issued; finish once the last is accepted.
        if (cnt_q == FRAME_A) begin
          if (stage_free) begin
            clr_pend_d = 1'b0;
            cnt_d      = '0;
            state_d    = RUN;
          end
        end else if (stage_free) begin
          we_d   = 1'b1;
          addr_d = base + cnt_q;
          data_d = clr_col_q;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      buf_q        <= 1'b0;
      swap_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      clr_col_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      buf_q        <= buf_d;
      swap_q       <= swap_d;
      frame_pend_q <= frame_pend_d;
      clr_pend_q   <= clr_pend_d;
      clr_col_q    <= clr_col_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef FB_STATS_EN
  logic [31:0] st_wr_q, st_dr_q;
  logic [15:0] st_fr_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_wr_q <= '0;
      st_dr_q <= '0;
      st_fr_q <= '0;
    end else begin
      if (we_q && mem_ready)                st_wr_q <= st_wr_q + 1'b1;
      if (gpu_hs && gpu_draw && !in_range)  st_dr_q <= st_dr_q + 1'b1;
      if (state_q == SWAP)                  st_fr_q <= st_fr_q + 1'b1;
    end
  end
  assign stat_written = st_wr_q;
  assign stat_dropped = st_dr_q;
  assign stat_frames  = st_fr_q;
`endif

endmodule
